spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  Byte-level command decoder sitting directly downstream of the SPI slave.
//  Consumes the slave's RX byte stream (o_RX_DV/o_RX_Byte) and drives its TX load (i_TX_DV/i_TX_Byte).
//  Decodes each CS-framed transaction into single-cycle register-bus reads/writes with address auto-increment.
//  Frame format: byte0 = {RW, ADDR[6:0]} (RW=1 read); every following byte is write data, or a dummy byte for reads.
// PARAMETERS
//  ADDR_WIDTH   7      register address width; must be <=7 (byte0 bits above ADDR_WIDTH ignored)
//  STATUS_BYTE  8'hA5  byte loaded to MISO at frame start, shifted out during byte0
// PORTS
//  i_Clk         in   1   FPGA clock; same clock as the SPI slave
//  i_Rst_L       in   1   asynchronous, active-low reset
//  i_SPI_CS_n    in   1   raw SPI chip select, asynchronous; synchronised internally
//  i_RX_DV       in   1   from slave o_RX_DV; 1-cycle byte-valid pulse
//  i_RX_Byte     in   8   from slave o_RX_Byte
//  o_TX_DV       out  1   to slave i_TX_DV; 1-cycle load pulse
//  o_TX_Byte     out  8   to slave i_TX_Byte
//  o_Reg_Addr    out  ADDR_WIDTH  register-bus address
//  o_Reg_Wr      out  1   1-cycle write strobe
//  o_Reg_WData   out  8   write data; valid with o_Reg_Wr
//  o_Reg_Rd      out  1   1-cycle read strobe
//  i_Reg_RData   in   8   read data; valid exactly 1 cycle after o_Reg_Rd
//  o_Busy        out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE. CS synchroniser flops reset to 1.
//  CS sync: 2-flop synchroniser plus an edge register. Fall = frame start; rise = frame end.
//  Frame start: o_TX_DV=1 and o_TX_Byte=STATUS_BYTE for 1 cycle, 3 cycles after the CS_n fall.
//    Host must leave >=4 i_Clk between CS_n low and the first SCLK edge.
//  States: IDLE, CMD, WRITE, RD_ISSUE, RD_CAPTURE, READ.
//  IDLE->CMD on frame start.
//  CMD, i_RX_DV with RW=0: latch addr, go WRITE.
//  CMD, i_RX_DV with RW=1: latch addr, go RD_ISSUE.
//  WRITE, on i_RX_DV (1 cycle later):
//    o_Reg_Wr=1, o_Reg_WData=byte, o_Reg_Addr=addr.
//    o_TX_DV=1 with o_TX_Byte=byte (echo).
//    addr increments. Stay in WRITE.
//  RD_ISSUE: o_Reg_Rd=1 at addr -> RD_CAPTURE.
//  RD_CAPTURE: o_TX_DV=1, o_TX_Byte=i_Reg_RData, addr increments -> READ.
//  Read latency: command byte DV to o_TX_DV = 3 cycles.
//  READ, on i_RX_DV (dummy byte, value ignored): -> RD_ISSUE (prefetch next register).
//  Addr wrap: 2^ADDR_WIDTH-1 increments to 0. No error flagged.
//  Frame end (synced CS rise) from any state: -> IDLE next cycle.
//    An i_RX_DV in the same cycle is still processed (write strobe issued), then IDLE.
//    A read in flight (RD_ISSUE/RD_CAPTURE) is completed on the bus but o_TX_DV is suppressed.
//  i_RX_DV while in IDLE (CS already high): ignored, no strobes.
//  i_RX_DV while in RD_ISSUE/RD_CAPTURE: cannot occur when i_Clk >= 4x SCLK; ignored if it does.
//  o_Reg_Wr and o_Reg_Rd are never high in the same cycle.
//  o_Reg_Addr holds its value between strobes.
//  Reset asserted mid-frame: immediate IDLE, strobes drop. Decoding resumes only at the next CS fall.
// TESTING
//  Reset: hold i_Rst_L=0 -> all outputs 0, o_Busy=0.
//    Release with CS_n high -> no TX_DV.
//  Write burst: CS low, bytes 0x10,0xAA,0xBB, CS high.
//    -> STATUS 0xA5 loaded.
//    -> Wr at 0x10 data 0xAA, then Wr at 0x11 data 0xBB.
//    -> Echo TX_DV 0xAA, 0xBB. Busy drops after CS high.
//  Read burst: CS low, bytes 0x85,0x00,0x00; model RData=addr^0xFF.
//    -> Rd at 0x05,0x06,0x07.
//    -> TX_DV bytes 0xFA,0xF9,0xF8, each 3 cycles after its RX_DV.
//  Wrap: write 0x7F then 0x01,0x02.
//    -> Wr at 0x7F data 0x01, then Wr at 0x00 data 0x02.
//  Simultaneous end: last write RX_DV in the same cycle as synced CS rise.
//    -> write strobe still issued, then IDLE.
//    -> Next frame starts in CMD.
//  Mid-frame reset: assert i_Rst_L=0 during a read burst.
//    -> no further strobes.
//    -> Stray RX_DV after release with CS high is ignored.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - byte stream and register bus bundle for spi_reg_bridge
//
// Groups the SPI slave byte stream and the register bus between the bridge
// and its neighbours.
//   master : the bridge itself (consumes RX bytes, drives TX load and register bus)
//   slave  : the surrounding logic (SPI slave + register file)
// Signals:
//   RX_DV / RX_Byte      byte-valid pulse and byte from the SPI slave
//   TX_DV / TX_Byte      load pulse and byte to the SPI slave
//   Reg_Addr             register address, holds between strobes
//   Reg_Wr / Reg_WData   1-cycle write strobe and its data
//   Reg_Rd / Reg_RData   1-cycle read strobe; read data valid the following cycle

interface spi_reg_bridge_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  RX_DV;
  logic [7:0]            RX_Byte;
  logic                  TX_DV;
  logic [7:0]            TX_Byte;
  logic [ADDR_WIDTH-1:0] Reg_Addr;
  logic                  Reg_Wr;
  logic [7:0]            Reg_WData;
  logic                  Reg_Rd;
  logic [7:0]            Reg_RData;

  modport master (
    input  RX_DV, RX_Byte, Reg_RData,
    output TX_DV, TX_Byte, Reg_Addr, Reg_Wr, Reg_WData, Reg_Rd
  );

  modport slave (
    output RX_DV, RX_Byte, Reg_RData,
    input  TX_DV, TX_Byte, Reg_Addr, Reg_Wr, Reg_WData, Reg_Rd
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register bus command decoder
//
// Decodes each chip-select framed SPI transaction into register reads and
// writes with address auto-increment. Byte0 = {RW, ADDR}; RW=1 reads.
// Ports:
//   i_Clk       clock shared with the SPI slave
//   i_Rst_L     asynchronous active-low reset
//   i_SPI_CS_n  raw chip select, synchronised here
//   bus         spi_reg_bridge_if master: RX stream in, TX load out, register bus
//   o_Busy      high whenever the decoder is not idle

module spi_reg_bridge #(
  parameter int         ADDR_WIDTH  = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  spi_reg_bridge_if.master  bus,
  output logic              o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_READ
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  cs_meta_q, cs_sync_q, cs_prev_q;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_dv_q, tx_dv_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  cs_fall, cs_rise;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  // Edge register sits behind the 2-flop synchroniser; all flops idle high.
  assign cs_fall  = cs_prev_q & ~cs_sync_q;
  assign cs_rise  = ~cs_prev_q & cs_sync_q;
  assign cmd_addr = bus.RX_Byte[ADDR_WIDTH-1:0];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      ptr_q      <= '0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_meta_q  <= i_SPI_CS_n;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      ptr_q      <= ptr_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = STATUS_BYTE;
          state_d   = S_CMD;
        end
      end

      S_CMD: begin
        if (bus.RX_DV) begin
          ptr_d = cmd_addr;
          if (bus.RX_Byte[7]) begin
            // A read is only launched if the frame is not ending this cycle.
            if (!cs_rise) begin
              reg_addr_d = cmd_addr;
              rd_d       = 1'b1;
            end
            state_d = S_RD_ISSUE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (bus.RX_DV) begin
          wr_d       = 1'b1;
          wdata_d    = bus.RX_Byte;
          reg_addr_d = ptr_q;
          tx_dv_d    = 1'b1;
          tx_byte_d  = bus.RX_Byte;
          ptr_d      = ptr_q + ADDR_ONE;
        end
      end

      // rd_q is high for exactly this state; read data arrives next cycle.
      S_RD_ISSUE: begin
        state_d = S_RD_CAPTURE;
      end

      S_RD_CAPTURE: begin
        tx_dv_d   = ~cs_rise;
        tx_byte_d = bus.Reg_RData;
        ptr_d     = ptr_q + ADDR_ONE;
        state_d   = S_READ;
      end

      // Dummy byte value is ignored; it only paces the prefetch of the next register.
      S_READ: begin
        if (bus.RX_DV && !cs_rise) begin
          reg_addr_d = ptr_q;
          rd_d       = 1'b1;
          state_d    = S_RD_ISSUE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (cs_rise) begin
      state_d = S_IDLE;
    end
  end

  assign bus.TX_DV     = tx_dv_q;
  assign bus.TX_Byte   = tx_byte_q;
  assign bus.Reg_Addr  = reg_addr_q;
  assign bus.Reg_Wr    = wr_q;
  assign bus.Reg_WData = wdata_q;
  assign bus.Reg_Rd    = rd_q;
  assign o_Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge

module tb_spi_reg_bridge;

  localparam int GAP = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic cs_n;
  logic busy;
  int   cyc = 0;

  spi_reg_bridge_if #(.ADDR_WIDTH(7)) bus ();

  spi_reg_bridge #(.ADDR_WIDTH(7), .STATUS_BYTE(8'hA5)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_SPI_CS_n (cs_n),
    .bus        (bus),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observed bus activity, sampled on the falling edge.
  logic [7:0] mon_tx[$];
  int         mon_txc[$];
  logic [6:0] mon_wa[$];
  logic [7:0] mon_wd[$];
  logic [6:0] mon_ra[$];
  int         viol = 0;
  logic [6:0] prev_addr = '0;

  always @(negedge clk) begin
    if (bus.TX_DV) begin
      mon_tx.push_back(bus.TX_Byte);
      mon_txc.push_back(cyc);
    end
    if (bus.Reg_Wr) begin
      mon_wa.push_back(bus.Reg_Addr);
      mon_wd.push_back(bus.Reg_WData);
    end
    if (bus.Reg_Rd) mon_ra.push_back(bus.Reg_Addr);
    if (bus.Reg_Wr && bus.Reg_Rd) viol++;
    if (rst_n && !bus.Reg_Wr && !bus.Reg_Rd && bus.Reg_Addr !== prev_addr) viol++;
    prev_addr = bus.Reg_Addr;
  end

  task automatic clear_mon();
    mon_tx.delete(); mon_txc.delete();
    mon_wa.delete(); mon_wd.delete(); mon_ra.delete();
  endtask

  // Register file model: read data is addr ^ 0xFF exactly one cycle after the
  // strobe, random noise at all other times.
  logic       rd_prev = 1'b0;
  logic [6:0] ra_prev = '0;
  initial begin
    bus.Reg_RData = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.Reg_RData = rd_prev ? ({1'b0, ra_prev} ^ 8'hFF) : 8'($urandom);
      rd_prev = bus.Reg_Rd;
      ra_prev = bus.Reg_Addr;
    end
  end

  // Frame driver
  logic [7:0] fr_bytes[$];
  int         drv_dvc[$];
  int         fall_cyc;

  task automatic send(input logic [7:0] b);
    drv_dvc.push_back(cyc);
    bus.RX_DV   = 1'b1;
    bus.RX_Byte = b;
    tick(1);
    bus.RX_DV   = 1'b0;
    bus.RX_Byte = 8'($urandom);
    tick(GAP - 1);
  endtask

  task automatic run_frame(input string tag);
    clear_mon();
    drv_dvc.delete();
    cs_n = 1'b0;
    fall_cyc = cyc;
    tick(6);
    chk($sformatf("%s busy_in_frame", tag), busy, 1);
    foreach (fr_bytes[i]) send(fr_bytes[i]);
    tick(4);
    cs_n = 1'b1;
    tick(6);
    chk($sformatf("%s busy_after_frame", tag), busy, 0);
  endtask

  // Reference model: expected register traffic and MISO loads from frame rules.
  logic [7:0] exp_tx[$];
  int         exp_txc[$];
  logic [6:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [6:0] exp_ra[$];

  task automatic build_model();
    int base;
    exp_tx.delete(); exp_txc.delete();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    exp_tx.push_back(8'hA5);
    exp_txc.push_back(fall_cyc + 3);
    base = int'(fr_bytes[0]) % 128;
    if (fr_bytes[0] < 8'h80) begin
      for (int i = 1; i < fr_bytes.size(); i++) begin
        exp_wa.push_back(7'((base + i - 1) % 128));
        exp_wd.push_back(fr_bytes[i]);
        exp_tx.push_back(fr_bytes[i]);
        exp_txc.push_back(drv_dvc[i] + 1);
      end
    end else begin
      for (int i = 0; i < fr_bytes.size(); i++) begin
        exp_ra.push_back(7'((base + i) % 128));
        exp_tx.push_back(8'(255 - ((base + i) % 128)));
        exp_txc.push_back(drv_dvc[i] + 3);
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    chk($sformatf("%s tx_count", tag), mon_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < mon_tx.size(); i++) begin
      chk($sformatf("%s tx[%0d]", tag, i), mon_tx[i], exp_tx[i]);
      chk($sformatf("%s tx_cycle[%0d]", tag, i), mon_txc[i], exp_txc[i]);
    end
    chk($sformatf("%s wr_count", tag), mon_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), mon_wa[i], exp_wa[i]);
      chk($sformatf("%s wr_data[%0d]", tag, i), mon_wd[i], exp_wd[i]);
    end
    chk($sformatf("%s rd_count", tag), mon_ra.size(), exp_ra.size());
    for (int i = 0; i < exp_ra.size() && i < mon_ra.size(); i++)
      chk($sformatf("%s rd_addr[%0d]", tag, i), mon_ra[i], exp_ra[i]);
  endtask

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b[4];
    int         n_wr;
    logic [6:0] wa[4];
    logic [7:0] wd[4];
    int         n_rd;
    logic [6:0] ra[4];
    int         n_tx;
    logic [7:0] tx[5];
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cs_n = 1'b1;
    bus.RX_DV = 1'b0;
    bus.RX_Byte = 8'h00;
    tick(3);
    chk("reset tx_dv", bus.TX_DV, 0);
    chk("reset tx_byte", bus.TX_Byte, 0);
    chk("reset reg_addr", bus.Reg_Addr, 0);
    chk("reset reg_wr", bus.Reg_Wr, 0);
    chk("reset reg_wdata", bus.Reg_WData, 0);
    chk("reset reg_rd", bus.Reg_Rd, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    tick(8);
    chk("release no_tx", mon_tx.size(), 0);
    chk("release busy", busy, 0);

    tbl[0].name = "wr_burst"; tbl[0].n = 3; tbl[0].b = '{8'h10, 8'hAA, 8'hBB, 8'h00};
    tbl[0].n_wr = 2; tbl[0].wa = '{7'h10, 7'h11, 7'h00, 7'h00}; tbl[0].wd = '{8'hAA, 8'hBB, 8'h00, 8'h00};
    tbl[0].n_rd = 0; tbl[0].ra = '{7'h00, 7'h00, 7'h00, 7'h00};
    tbl[0].n_tx = 3; tbl[0].tx = '{8'hA5, 8'hAA, 8'hBB, 8'h00, 8'h00};

    tbl[1].name = "rd_burst"; tbl[1].n = 3; tbl[1].b = '{8'h85, 8'h00, 8'h00, 8'h00};
    tbl[1].n_wr = 0; tbl[1].wa = '{7'h00, 7'h00, 7'h00, 7'h00}; tbl[1].wd = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].n_rd = 3; tbl[1].ra = '{7'h05, 7'h06, 7'h07, 7'h00};
    tbl[1].n_tx = 4; tbl[1].tx = '{8'hA5, 8'hFA, 8'hF9, 8'hF8, 8'h00};

    tbl[2].name = "wr_wrap"; tbl[2].n = 3; tbl[2].b = '{8'h7F, 8'h01, 8'h02, 8'h00};
    tbl[2].n_wr = 2; tbl[2].wa = '{7'h7F, 7'h00, 7'h00, 7'h00}; tbl[2].wd = '{8'h01, 8'h02, 8'h00, 8'h00};
    tbl[2].n_rd = 0; tbl[2].ra = '{7'h00, 7'h00, 7'h00, 7'h00};
    tbl[2].n_tx = 3; tbl[2].tx = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00};

    tbl[3].name = "rd_wrap"; tbl[3].n = 3; tbl[3].b = '{8'hFE, 8'h00, 8'h00, 8'h00};
    tbl[3].n_wr = 0; tbl[3].wa = '{7'h00, 7'h00, 7'h00, 7'h00}; tbl[3].wd = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].n_rd = 3; tbl[3].ra = '{7'h7E, 7'h7F, 7'h00, 7'h00};
    tbl[3].n_tx = 4; tbl[3].tx = '{8'hA5, 8'h81, 8'h80, 8'hFF, 8'h00};

    tbl[4].name = "cmd_only"; tbl[4].n = 1; tbl[4].b = '{8'h42, 8'h00, 8'h00, 8'h00};
    tbl[4].n_wr = 0; tbl[4].wa = '{7'h00, 7'h00, 7'h00, 7'h00}; tbl[4].wd = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].n_rd = 0; tbl[4].ra = '{7'h00, 7'h00, 7'h00, 7'h00};
    tbl[4].n_tx = 1; tbl[4].tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};

    // Directed vectors: constant expectations from the table, timing from the model.
    foreach (tbl[k]) begin
      fr_bytes.delete();
      for (int j = 0; j < tbl[k].n; j++) fr_bytes.push_back(tbl[k].b[j]);
      run_frame(tbl[k].name);
      build_model();
      exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
      for (int j = 0; j < tbl[k].n_tx; j++) exp_tx.push_back(tbl[k].tx[j]);
      for (int j = 0; j < tbl[k].n_wr; j++) begin
        exp_wa.push_back(tbl[k].wa[j]);
        exp_wd.push_back(tbl[k].wd[j]);
      end
      for (int j = 0; j < tbl[k].n_rd; j++) exp_ra.push_back(tbl[k].ra[j]);
      compare_frame(tbl[k].name);
    end

    // Randomised frames against the reference model.
    for (int k = 0; k < 16; k++) begin
      int n;
      n = $urandom_range(1, 4);
      fr_bytes.delete();
      for (int j = 0; j < n; j++) fr_bytes.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", k));
      build_model();
      compare_frame($sformatf("rand%0d", k));
    end

    // Last write byte arrives in the same cycle as the synchronised CS rise.
    clear_mon();
    cs_n = 1'b0;
    tick(6);
    send(8'h20);
    send(8'h11);
    cs_n = 1'b1;
    tick(2);
    bus.RX_DV = 1'b1;
    bus.RX_Byte = 8'h22;
    tick(1);
    bus.RX_DV = 1'b0;
    chk("simul_end wr", bus.Reg_Wr, 1);
    chk("simul_end addr", bus.Reg_Addr, 7'h21);
    chk("simul_end wdata", bus.Reg_WData, 8'h22);
    chk("simul_end busy", busy, 0);
    tick(6);
    chk("simul_end wr_count", mon_wa.size(), 2);

    fr_bytes = '{8'h30, 8'h5A};
    run_frame("after_simul_end");
    build_model();
    compare_frame("after_simul_end");

    // Reset asserted while a read strobe is on the bus.
    clear_mon();
    cs_n = 1'b0;
    tick(6);
    bus.RX_DV = 1'b1;
    bus.RX_Byte = 8'h83;
    tick(1);
    bus.RX_DV = 1'b0;
    chk("midreset rd_before", bus.Reg_Rd, 1);
    rst_n = 1'b0;
    clear_mon();
    tick(1);
    chk("midreset rd", bus.Reg_Rd, 0);
    chk("midreset tx_dv", bus.TX_DV, 0);
    chk("midreset addr", bus.Reg_Addr, 0);
    chk("midreset busy", busy, 0);
    cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    send(8'h05);
    send(8'h99);
    tick(4);
    chk("midreset wr_count", mon_wa.size(), 0);
    chk("midreset rd_count", mon_ra.size(), 0);
    chk("midreset tx_count", mon_tx.size(), 0);
    chk("midreset busy_after", busy, 0);

    chk("strobe_invariants", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
